// File: rtl/dac_word_unpacker_if.sv
// dac_word_unpacker_if: 64-bit word valid/ready stream into the DAC word unpacker
interface dac_word_unpacker_if;
   logic [63:0] in_data;
   logic        in_valid;
   logic        in_ready;
   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/dac_word_unpacker.sv
// dac_word_unpacker: streams buffered 64-bit words to an 8-bit DAC port, LSB first, with underrun accounting
module dac_word_unpacker #(
   parameter logic [7:0] IDLE_CODE = 8'h80,
   parameter int         CNT_W     = 16
) (
   input  logic               adc_clk,
   input  logic               rst_n,
   dac_word_unpacker_if.slave bus,
   input  logic               enable,
   input  logic               clr_stats,
   output logic [7:0]         dac_data,
   output logic               dac_valid,
   output logic               word_start,
   output logic               underrun,
   output logic [CNT_W-1:0]   underrun_cnt
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state, state_n;
   logic [63:0]      hold, hold_n, active, active_n;
   logic             hold_full, hold_full_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       data_n;
   logic             valid_n, start_n, ur_n;
   logic [CNT_W-1:0] cnt_n;
   logic             accept, load, mid;
   assign bus.in_ready = !hold_full;
   // next state: a word boundary (IDLE or byte 7 showing) either loads the buffered word or stops
   always_comb begin
      accept      = bus.in_valid && !hold_full;
      load        = (state == IDLE || idx == 3'd0) && enable && hold_full;
      mid         = (state == RUN) && (idx != 3'd0);
      hold_n      = accept ? bus.in_data : hold;
      hold_full_n = load ? 1'b0 : (accept ? 1'b1 : hold_full);
      active_n    = load ? hold : active;
      idx_n       = load ? 3'd1 : (mid ? idx + 3'd1 : idx);
      data_n      = load ? hold[7:0] : (mid ? active[{idx, 3'b000} +: 8] : IDLE_CODE);
      valid_n     = load || mid;
      start_n     = load;
      ur_n        = (state == RUN) && !mid && !load && enable;
      cnt_n       = clr_stats ? '0 :
                    ((ur_n && !(&underrun_cnt)) ? underrun_cnt + CNT_W'(1) : underrun_cnt);
      state_n     = (load || mid) ? RUN : IDLE;
   end
   // state and output registers; reset drops both words and forces idle outputs at once
   always_ff @(posedge adc_clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         hold         <= '0;
         hold_full    <= 1'b0;
         active       <= '0;
         idx          <= 3'd0;
         dac_data     <= IDLE_CODE;
         dac_valid    <= 1'b0;
         word_start   <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         state        <= state_n;
         hold         <= hold_n;
         hold_full    <= hold_full_n;
         active       <= active_n;
         idx          <= idx_n;
         dac_data     <= data_n;
         dac_valid    <= valid_n;
         word_start   <= start_n;
         underrun     <= ur_n;
         underrun_cnt <= cnt_n;
      end
   end
endmodule
